// File: rtl/baccarat_dealer_fsm.sv
// Baccarat dealer control: deal sequencing, punto-banco third-card rules, win decode.
// Optional hand tallies are built when BACCARAT_TALLY_EN is defined.
module baccarat_dealer_fsm #(
  parameter int NATURAL_MIN     = 8,
  parameter int PLAYER_DRAW_MAX = 5
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  input  logic       next_hand,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       clr_cards,
  output logic       player_win,
  output logic       dealer_win,
  output logic [7:0] tally_player,
  output logic [7:0] tally_dealer,
  output logic [7:0] tally_tie
);

  typedef enum logic [3:0] {
    S_RST, S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_EVAL3, S_D3, S_DONE, S_CLR
  } state_t;

  state_t state, next_state;
  logic [3:0] pv;
  logic       dealer_draw;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state <= S_RST;
    else         state <= next_state;
  end

  // Face cards and tens count as zero when judging the dealer's third card.
  always_comb begin
    pv          = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
    dealer_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draw = 1'b1;
      4'd3:             dealer_draw = (pv != 4'd8);
      4'd4:             dealer_draw = (pv >= 4'd2) && (pv <= 4'd7);
      4'd5:             dealer_draw = (pv >= 4'd4) && (pv <= 4'd7);
      4'd6:             dealer_draw = (pv >= 4'd6) && (pv <= 4'd7);
      default:          dealer_draw = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RST:   next_state = S_P1;
      S_P1:    next_state = S_D1;
      S_D1:    next_state = S_P2;
      S_P2:    next_state = S_D2;
      S_D2:    next_state = S_EVAL;
      S_EVAL: begin
        if (pscore >= 4'(NATURAL_MIN) || dscore >= 4'(NATURAL_MIN)) next_state = S_DONE;
        else if (pscore <= 4'(PLAYER_DRAW_MAX))                     next_state = S_P3;
        else if (dscore <= 4'(PLAYER_DRAW_MAX))                     next_state = S_D3;
        else                                                        next_state = S_DONE;
      end
      S_P3:    next_state = S_EVAL3;
      S_EVAL3: next_state = dealer_draw ? S_D3 : S_DONE;
      S_D3:    next_state = S_DONE;
      S_DONE:  next_state = next_hand ? S_CLR : S_DONE;
      S_CLR:   next_state = S_P1;
      default: next_state = S_RST;
    endcase
  end

  assign load_pcard1 = (state == S_P1);
  assign load_dcard1 = (state == S_D1);
  assign load_pcard2 = (state == S_P2);
  assign load_dcard2 = (state == S_D2);
  assign load_pcard3 = (state == S_P3);
  assign load_dcard3 = (state == S_D3);
  assign clr_cards   = (state == S_CLR);
  assign player_win  = (state == S_DONE) && (pscore >= dscore);
  assign dealer_win  = (state == S_DONE) && (dscore >= pscore);

`ifdef BACCARAT_TALLY_EN
  // Count on the first S_DONE cycle: a dealer third card only settles dscore there.
  logic done_q;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      done_q       <= 1'b0;
      tally_player <= 8'd0;
      tally_dealer <= 8'd0;
      tally_tie    <= 8'd0;
    end else begin
      done_q <= (state == S_DONE);
      if (state == S_DONE && !done_q) begin
        if (player_win && dealer_win) begin
          if (tally_tie != 8'hff) tally_tie <= tally_tie + 8'd1;
        end else if (player_win) begin
          if (tally_player != 8'hff) tally_player <= tally_player + 8'd1;
        end else if (dealer_win) begin
          if (tally_dealer != 8'hff) tally_dealer <= tally_dealer + 8'd1;
        end
      end
    end
  end
`else
  assign tally_player = 8'd0;
  assign tally_dealer = 8'd0;
  assign tally_tie    = 8'd0;
`endif

endmodule

// File: tb/tb_baccarat_dealer_fsm.sv
// Directed bench for baccarat_dealer_fsm; tally expectations follow BACCARAT_TALLY_EN.
module tb_baccarat_dealer_fsm;

`ifdef BACCARAT_TALLY_EN
  localparam int TALLY = 1;
`else
  localparam int TALLY = 0;
`endif

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic       next_hand  = 1'b0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       clr_cards, player_win, dealer_win;
  logic [7:0] tally_player, tally_dealer, tally_tie;

  int checks   = 0;
  int failures = 0;

  baccarat_dealer_fsm dut (
    .slow_clock  (slow_clock),
    .resetb      (resetb),
    .pscore      (pscore),
    .dscore      (dscore),
    .pcard3      (pcard3),
    .next_hand   (next_hand),
    .load_pcard1 (load_pcard1),
    .load_pcard2 (load_pcard2),
    .load_pcard3 (load_pcard3),
    .load_dcard1 (load_dcard1),
    .load_dcard2 (load_dcard2),
    .load_dcard3 (load_dcard3),
    .clr_cards   (clr_cards),
    .player_win  (player_win),
    .dealer_win  (dealer_win),
    .tally_player(tally_player),
    .tally_dealer(tally_dealer),
    .tally_tie   (tally_tie)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  function automatic int outs();
    return int'({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
                 load_dcard3, clr_cards, player_win, dealer_win});
  endfunction

  // Independent statement of the dealer third-card table.
  function automatic int draws(input int d, input int c);
    int v;
    v = (c >= 10) ? 0 : c;
    if (d <= 2) return 1;
    if (d == 3) return (v == 8) ? 0 : 1;
    if (d == 4) return (v >= 2 && v <= 7) ? 1 : 0;
    if (d == 5) return (v >= 4 && v <= 7) ? 1 : 0;
    if (d == 6) return (v == 6 || v == 7) ? 1 : 0;
    return 0;
  endfunction

  // Starts in S_RST or S_CLR; edges are counted from there.
  task automatic run_hand(input string tag, input int ps, input int ds, input int p3,
                          input int e_p3, input int e_d3, input int e_lat,
                          input int e_pw, input int e_dw, input bit full);
    int p3e = 0, d3e = 0, lat = 0, pw = 0, dw = 0;
    pscore = 4'(ps);
    dscore = 4'(ds);
    pcard3 = 4'(p3);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (full && i == 1) chk({tag, "_pcard1"}, int'(load_pcard1), 1);
      if (load_pcard3 && p3e == 0) p3e = i;
      if (load_dcard3 && d3e == 0) d3e = i;
      if (player_win || dealer_win) begin
        lat = i; pw = int'(player_win); dw = int'(dealer_win);
        break;
      end
    end
    chk({tag, "_lat"}, lat, e_lat);
    if (full) begin
      chk({tag, "_p3edge"}, p3e, e_p3);
      chk({tag, "_d3edge"}, d3e, e_d3);
      chk({tag, "_pwin"}, pw, e_pw);
      chk({tag, "_dwin"}, dw, e_dw);
    end
  endtask

  // Hold one cycle in S_DONE, then request the next hand.
  task automatic new_hand(input bit full);
    step();
    if (full) chk("done_hold", int'(player_win | dealer_win), 1);
    next_hand = 1'b1;
    step();
    next_hand = 1'b0;
    if (full) begin
      chk("clr_cards", int'(clr_cards), 1);
      chk("clr_nowin", int'(player_win | dealer_win), 0);
    end
  endtask

  initial begin
    #1;
    chk("rst_outs", outs(), 0);
    chk("rst_tally", int'({tally_player, tally_dealer, tally_tie}), 0);
    #21 resetb = 1'b1;

    run_hand("natural",    9, 3, 0,  0, 0, 6, 1, 0, 1); new_hand(1);
    run_hand("both_draw",  4, 3, 7,  6, 8, 9, 1, 0, 1); new_hand(1);
    run_hand("p_draw_v8",  4, 3, 8,  6, 0, 8, 1, 0, 1); new_hand(1);
    run_hand("face_v0",    4, 5, 12, 6, 0, 8, 0, 1, 1); new_hand(1);
    run_hand("d_draw",     6, 5, 0,  0, 6, 7, 1, 0, 1); new_hand(1);
    run_hand("tie",        7, 7, 0,  0, 0, 6, 1, 1, 1); new_hand(1);
    run_hand("both_stand", 6, 7, 0,  0, 0, 6, 0, 1, 1); new_hand(1);

    for (int d = 0; d <= 7; d++)
      for (int c = 1; c <= 13; c++) begin
        run_hand($sformatf("rule_d%0d_c%0d", d, c), 4, d, c, 0, 0,
                 draws(d, c) ? 9 : 8, 0, 0, 0);
        new_hand(0);
      end

    // Abandon a hand while the player's third card is loading.
    pscore = 4'd4; dscore = 4'd3; pcard3 = 4'd7;
    repeat (6) step();
    chk("mid_in_p3", int'(load_pcard3), 1);
    #2 resetb = 1'b0;
    #1;
    chk("mid_rst_outs", outs(), 0);
    chk("mid_rst_tally", int'({tally_player, tally_dealer, tally_tie}), 0);
    #2 resetb = 1'b1;

    run_hand("post_rst", 9, 3, 0, 0, 0, 6, 1, 0, 1); new_hand(1);
    run_hand("dealer",   3, 9, 0, 0, 0, 6, 0, 1, 1); new_hand(1);
    run_hand("tie2",     5, 5, 10, 6, 0, 8, 1, 1, 1); new_hand(1);
    chk("tally_p1", int'(tally_player), TALLY * 1);
    chk("tally_d1", int'(tally_dealer), TALLY * 1);
    chk("tally_t1", int'(tally_tie),    TALLY * 1);

    for (int h = 0; h < 255; h++) begin
      run_hand("sat", 9, 0, 0, 0, 0, 6, 1, 0, 0);
      new_hand(0);
    end
    chk("tally_p_sat", int'(tally_player), TALLY * 255);
    chk("tally_d_keep", int'(tally_dealer), TALLY * 1);
    chk("tally_t_keep", int'(tally_tie),    TALLY * 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baccarat_dealer_fsm.md
Name: baccarat_dealer_fsm

Overview:
- Control stage of the baccarat datapath. Sequences dealing of player/dealer cards through the card-load strobes.
- Consumes the combinational hand totals produced by the per-hand scoring blocks, plus the player's third-card rank.
- Applies the punto-banco third-card rules and produces the win indications.
- Supports repeated hands without reset through a next_hand request.

Parameters:
- NATURAL_MIN, 8: hand total at or above which a two-card hand is a natural.
- PLAYER_DRAW_MAX, 5: player draws a third card when its two-card total is at or below this value.

Ports:
- slow_clock  in  1  single clock; all state changes on rising edge.
- resetb  in  1  asynchronous, active-low reset.
- pscore  in  4  player hand total, 0-9.
- dscore  in  4  dealer hand total, 0-9.
- pcard3  in  4  player third-card rank, 1-13 (0 = no card).
- next_hand  in  1  request a new hand; sampled only in S_DONE.
- load_pcard1, load_pcard2, load_pcard3  out  1 each  player card register load strobes.
- load_dcard1, load_dcard2, load_dcard3  out  1 each  dealer card register load strobes.
- clr_cards  out  1  datapath clears all six card registers to 0 at the next edge.
- player_win  out  1  player total >= dealer total, valid in S_DONE.
- dealer_win  out  1  dealer total >= player total, valid in S_DONE.
- tally_player, tally_dealer, tally_tie  out  8 each  hand counters (optional feature).

Behaviour:
- Moore machine; every output is decoded from the registered state. No input-to-output combinational path except player_win/dealer_win, which decode from state plus scores.
- Reset:
  - resetb low forces S_RST immediately; all outputs 0, tallies 0.
  - Reset mid-hand abandons the hand with no partial outcome.
- States and active output:
  - S_RST: all outputs 0.
  - S_P1: load_pcard1. S_D1: load_dcard1. S_P2: load_pcard2. S_D2: load_dcard2.
  - S_EVAL: no loads.
  - S_P3: load_pcard3.
  - S_EVAL3: no loads.
  - S_D3: load_dcard3.
  - S_DONE: win outputs.
  - S_CLR: clr_cards.
- Transitions:
  - Fixed deal order: S_RST->S_P1->S_D1->S_P2->S_D2->S_EVAL, unconditional.
  - S_EVAL:
    - pscore>=NATURAL_MIN or dscore>=NATURAL_MIN -> S_DONE.
    - else pscore<=PLAYER_DRAW_MAX -> S_P3.
    - else dscore<=PLAYER_DRAW_MAX -> S_D3.
    - else -> S_DONE.
  - S_P3->S_EVAL3.
  - S_EVAL3: v = value of pcard3, where ranks 10-13 map to 0 and ranks 1-9 map to their rank. Go to S_D3 when any of:
    - dscore<=2
    - dscore==3 and v!=8
    - dscore==4 and 2<=v<=7
    - dscore==5 and 4<=v<=7
    - dscore==6 and 6<=v<=7
  - S_EVAL3 otherwise (including dscore>=7) -> S_DONE.
  - S_D3->S_DONE.
  - S_DONE: holds while next_hand=0; next_hand=1 -> S_CLR.
  - S_CLR->S_P1.
- Load strobes:
  - Each strobe is exactly one cycle; the card registers at the closing edge.
  - Scores are read in the cycle after the last load, so S_EVAL and S_EVAL3 see settled totals.
- Latency in edges after reset release:
  - Natural, or both stand: S_DONE at 6.
  - Player stands, dealer draws: 7.
  - Player draws, dealer stands: 8.
  - Both draw: 9.
- Result: tie asserts both player_win and dealer_win. Both are 0 outside S_DONE.
- next_hand is ignored in every state other than S_DONE.

Optional Feature:
- Macro BACCARAT_TALLY_EN.
- Defined:
  - Three 8-bit counters increment once on each transition into S_DONE: player-only win -> tally_player; dealer-only win -> tally_dealer; tie -> tally_tie.
  - Counters saturate at 255.
  - Counters are cleared only by resetb; they are not cleared by clr_cards.
- Not defined: no counter logic; the tally ports remain and are tied to 8'd0.

Test Plan:
- Natural: pscore=9, dscore=3 at S_EVAL -> no load_pcard3/load_dcard3, S_DONE at edge 6, player_win=1, dealer_win=0.
- Player draws, dealer draws: pscore=4, dscore=3 at S_EVAL, pcard3=7 (v=7) -> load_pcard3 at edge 6, load_dcard3 at edge 8, S_DONE at 9. Same with pcard3=8 -> no load_dcard3, S_DONE at 8.
- Face-card value: dscore=5 at S_EVAL3, pcard3=12 (v=0) -> dealer stands. Exhaust dscore 0-7 x pcard3 1-13 against the rule table.
- Player stands, dealer draws: pscore=6, dscore=5 at S_EVAL -> load_dcard3 at edge 6, S_DONE at 7. Tie with pscore=dscore=7 -> both wins high.
- Mid-hand reset: resetb low during S_P3 -> all outputs 0 immediately; after release the sequence restarts at S_P1 and load_pcard1 is high at edge 1.
- next_hand with BACCARAT_TALLY_EN defined: three hands (player, dealer, tie) -> clr_cards one cycle after each next_hand; tallies 1/1/1. Forced 256 player wins -> tally_player=255.
